rs_stream_encoder: RTL and testbench

Parametrised systematic Reed-Solomon encoder with valid/ready streaming on both sides. It accepts LANES message symbols per beat and passes them through unchanged. When the frame ends it appends PAR_LEN parity symbols, computed by a LANES-wide unrolled LFSR. Message length is set at runtime by `in_last` (shortened codes), capped at the full code length. It sits between the framer and the line interface and succeeds the fixed-width stall-based encoder top.

---
 rtl/rs_stream_encoder_if.sv | 26 ++
 rtl/rs_stream_encoder.sv | 164 ++++++++++++++++
 tb/tb_rs_stream_encoder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_stream_encoder_if.sv
// Valid/ready bundle for the RS stream encoder: message beats in, codeword beats out.
// The encoder takes the slave modport; the upstream/downstream side takes master.
interface rs_stream_encoder_if #(
  parameter int unsigned SYM_W = 8,
  parameter int unsigned LANES = 4
);
  logic [LANES*SYM_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [LANES*SYM_W-1:0] out_data;
  logic                   out_valid;
  logic                   out_last;
  logic                   out_ready;
  logic                   err_len;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, err_len
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, err_len
  );
endinterface

// File: rtl/rs_stream_encoder.sv
// Systematic Reed-Solomon encoder: message beats pass through, then PAR_LEN parity
// symbols from a LANES-wide unrolled LFSR. Frames end on in_last or at MAX_BEATS.
module rs_stream_encoder #(
  parameter int unsigned SYM_W   = 8,
  parameter int unsigned LANES   = 4,
  parameter int unsigned PAR_LEN = 16,
  parameter int unsigned GF_POLY = 'h11D,
  parameter int unsigned FCR     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  rs_stream_encoder_if.slave bus
);
  localparam int unsigned BEAT_W    = LANES * SYM_W;
  localparam int unsigned LFSR_W    = PAR_LEN * SYM_W;
  localparam int unsigned MAX_BEATS = ((1 << SYM_W) - 1 - PAR_LEN) / LANES;
  localparam int unsigned N_PAR     = PAR_LEN / LANES;
  localparam int unsigned CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS + 1) : 1;
  localparam int unsigned PCNT_W    = (N_PAR > 1) ? $clog2(N_PAR) : 1;
  localparam logic [SYM_W-1:0] ALPHA = SYM_W'(2);
  localparam logic [SYM_W-1:0] ONE   = SYM_W'(1);

  if (PAR_LEN % LANES != 0) begin : g_par_check
    $fatal(1, "PAR_LEN must be a multiple of LANES");
  end
  if (PAR_LEN + LANES >= (1 << SYM_W)) begin : g_len_check
    $fatal(1, "PAR_LEN leaves no room for a message beat");
  end

  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W:0]   aa;
    logic [SYM_W:0]   poly;
    logic [SYM_W-1:0] p;
    poly = GF_POLY[SYM_W:0];
    aa   = {1'b0, a};
    p    = '0;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p ^= aa[SYM_W-1:0];
      aa = aa << 1;
      if (aa[SYM_W]) aa ^= poly;
    end
    return p;
  endfunction

  // Low PAR_LEN coefficients of the monic generator, coefficient j at [j*SYM_W +: SYM_W].
  function automatic logic [LFSR_W-1:0] gen_g_low();
    logic [(PAR_LEN+1)*SYM_W-1:0] gg;
    logic [SYM_W-1:0]             root;
    gg = '0;
    gg[SYM_W-1:0] = ONE;
    root = ONE;
    for (int i = 0; i < FCR; i++) root = gf_mul(root, ALPHA);
    for (int i = 0; i < PAR_LEN; i++) begin
      for (int j = PAR_LEN; j > 0; j--) begin
        gg[j*SYM_W +: SYM_W] = gg[(j-1)*SYM_W +: SYM_W] ^ gf_mul(gg[j*SYM_W +: SYM_W], root);
      end
      gg[SYM_W-1:0] = gf_mul(gg[SYM_W-1:0], root);
      root = gf_mul(root, ALPHA);
    end
    return gg[LFSR_W-1:0];
  endfunction

  localparam logic [LFSR_W-1:0] G_LOW = gen_g_low();

  // Highest lane is earliest in time, so it is absorbed first.
  function automatic logic [LFSR_W-1:0] lfsr_absorb(input logic [LFSR_W-1:0] r,
                                                    input logic [BEAT_W-1:0] d);
    logic [LFSR_W-1:0] s;
    logic [SYM_W-1:0]  fb;
    s = r;
    for (int l = LANES - 1; l >= 0; l--) begin
      fb = d[l*SYM_W +: SYM_W] ^ s[LFSR_W-1 -: SYM_W];
      s  = s << SYM_W;
      for (int j = 0; j < PAR_LEN; j++) begin
        s[j*SYM_W +: SYM_W] ^= gf_mul(fb, G_LOW[j*SYM_W +: SYM_W]);
      end
    end
    return s;
  endfunction

  typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

  state_e              r_state, w_state_nxt;
  logic [LFSR_W-1:0]   r_lfsr, w_lfsr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [PCNT_W-1:0]   r_pcnt, w_pcnt_nxt;
  logic [BEAT_W-1:0]   r_out_data, w_out_data_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic                r_out_last, w_out_last_nxt;
  logic                r_err, w_err_nxt;
  logic                w_slot_free, w_in_ready, w_in_fire, w_hit_max, w_par_final;

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_in_ready  = w_slot_free && (r_state != StParity);
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_hit_max   = (r_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_par_final = (r_pcnt == PCNT_W'(N_PAR - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_lfsr_nxt      = r_lfsr;
    w_cnt_nxt       = r_cnt;
    w_pcnt_nxt      = r_pcnt;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_out_valid_nxt = r_out_valid && !bus.out_ready;
    w_err_nxt       = 1'b0;
    if (w_in_fire) begin
      w_out_data_nxt  = bus.in_data;
      w_out_valid_nxt = 1'b1;
      w_out_last_nxt  = 1'b0;
      w_lfsr_nxt      = lfsr_absorb(r_lfsr, bus.in_data);
      if (bus.in_last || w_hit_max) begin
        w_state_nxt = StParity;
        w_cnt_nxt   = '0;
        w_pcnt_nxt  = '0;
        w_err_nxt   = !bus.in_last;
      end else begin
        w_state_nxt = StData;
        w_cnt_nxt   = r_cnt + 1'b1;
      end
    end else if (r_state == StParity && w_slot_free) begin
      w_out_data_nxt  = r_lfsr[LFSR_W-1 -: BEAT_W];
      w_out_valid_nxt = 1'b1;
      w_out_last_nxt  = w_par_final;
      w_lfsr_nxt      = r_lfsr << BEAT_W;
      w_pcnt_nxt      = r_pcnt + 1'b1;
      if (w_par_final) begin
        w_lfsr_nxt  = '0;
        w_pcnt_nxt  = '0;
        w_state_nxt = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_lfsr      <= '0;
      r_cnt       <= '0;
      r_pcnt      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pcnt      <= w_pcnt_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.err_len   = r_err;
endmodule

// File: tb/tb_rs_stream_encoder.sv
// Bench for rs_stream_encoder: fixed vectors on a LANES=2/PAR_LEN=4 instance, and
// streamed frames on a default instance checked against a polynomial-division RS model.
module tb_rs_stream_encoder;
  localparam int MAXB = 59;
  localparam int NPAR = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rs_stream_encoder_if #(.SYM_W(8), .LANES(2)) bs ();
  rs_stream_encoder_if #(.SYM_W(8), .LANES(4)) bd ();

  rs_stream_encoder #(.SYM_W(8), .LANES(2), .PAR_LEN(4), .GF_POLY('h11D), .FCR(0)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bs)
  );

  rs_stream_encoder #(.SYM_W(8), .LANES(4), .PAR_LEN(16), .GF_POLY('h11D), .FCR(0)) dut_d (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bd)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic        eir;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        close;
    logic        trunc;
  } beat_t;

  beat_t in_q[$];
  beat_t exp_q[$];
  int    exp_t[512];
  int    log_t[256];
  int    gpoly[NPAR+1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic void gf_init();
    int x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    for (int i = 255; i < 512; i++) exp_t[i] = exp_t[i-255];
  endfunction

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[log_t[a] + log_t[b]];
  endfunction

  // g(x) = prod (x + alpha^i), i = 0..NPAR-1, stored by degree.
  function automatic void build_gpoly();
    int nx[NPAR+1];
    for (int j = 0; j <= NPAR; j++) gpoly[j] = 0;
    gpoly[0] = 1;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = 0; j <= NPAR; j++)
        nx[j] = gmul(gpoly[j], exp_t[i]) ^ ((j > 0) ? gpoly[j-1] : 0);
      for (int j = 0; j <= NPAR; j++) gpoly[j] = nx[j];
    end
  endfunction

  // Long division of m(x)*x^NPAR by g(x); remainder coefficients land after the message.
  task automatic add_parity(input int msg[$]);
    int    w[$];
    int    n;
    beat_t o;
    w = msg;
    n = msg.size();
    repeat (NPAR) w.push_back(0);
    for (int i = 0; i < n; i++) begin
      int c = w[i];
      if (c != 0)
        for (int j = 1; j <= NPAR; j++) w[i+j] = w[i+j] ^ gmul(c, gpoly[NPAR-j]);
    end
    for (int k = 0; k < NPAR / 4; k++) begin
      o.d = {8'(w[n+4*k]), 8'(w[n+4*k+1]), 8'(w[n+4*k+2]), 8'(w[n+4*k+3])};
      o.l = (k == NPAR / 4 - 1);
      o.close = 1'b0;
      o.trunc = 1'b0;
      exp_q.push_back(o);
    end
  endtask

  task automatic build_expected();
    int    msg[$];
    int    cnt = 0;
    beat_t b;
    beat_t o;
    exp_q.delete();
    for (int i = 0; i < in_q.size(); i++) begin
      b = in_q[i];
      for (int l = 3; l >= 0; l--) msg.push_back(int'(b.d[l*8 +: 8]));
      o.d = b.d;
      o.l = 1'b0;
      o.close = 1'b0;
      o.trunc = 1'b0;
      exp_q.push_back(o);
      cnt++;
      b.close = b.l || (cnt == MAXB);
      b.trunc = !b.l && (cnt == MAXB);
      in_q[i] = b;
      if (b.close) begin
        add_parity(msg);
        msg.delete();
        cnt = 0;
      end
    end
  endtask

  task automatic add_frame(input int len, input logic end_last);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = $urandom();
      b.l = end_last && (i == len - 1);
      b.close = 1'b0;
      b.trunc = 1'b0;
      in_q.push_back(b);
    end
  endtask

  // Streams in_q into the default instance and scoreboards every output beat.
  task automatic run_stream(input int vpct, input int rpct, input int stall_at);
    int          ii = 0;
    int          oi = 0;
    int          cyc = 0;
    int          stall_left = 5;
    logic        in_par = 1'b0;
    logic        exp_err = 1'b0;
    logic        held = 1'b0;
    logic [31:0] hd = '0;
    logic        hl = 1'b0;
    build_expected();
    while ((ii < in_q.size() || oi < exp_q.size()) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      check("err_len", bd.err_len, exp_err);
      if (held) begin
        check("stall_valid", bd.out_valid, 1'b1);
        check("stall_data", bd.out_data, hd);
        check("stall_last", bd.out_last, hl);
      end
      if (bd.out_valid && bd.out_last) in_par = 1'b0;
      if (stall_at >= 0 && oi == stall_at && bd.out_valid && stall_left > 0) begin
        bd.out_ready = 1'b0;
        stall_left--;
      end else begin
        bd.out_ready = ($urandom_range(99) < rpct);
      end
      if (ii < in_q.size()) begin
        bd.in_valid = ($urandom_range(99) < vpct);
        bd.in_data  = in_q[ii].d;
        bd.in_last  = in_q[ii].l;
      end else begin
        bd.in_valid = 1'b0;
        bd.in_data  = $urandom();
        bd.in_last  = 1'b0;
      end
      #1;
      if (in_par) check("in_ready_parity", bd.in_ready, 1'b0);
      else check("in_ready", bd.in_ready, !bd.out_valid || bd.out_ready);
      exp_err = 1'b0;
      if (bd.out_valid && bd.out_ready) begin
        if (oi < exp_q.size()) begin
          check($sformatf("out_data[%0d]", oi), bd.out_data, exp_q[oi].d);
          check($sformatf("out_last[%0d]", oi), bd.out_last, exp_q[oi].l);
        end else begin
          check("extra_beat", 1'b1, 1'b0);
        end
        oi++;
      end
      held = bd.out_valid && !bd.out_ready;
      hd   = bd.out_data;
      hl   = bd.out_last;
      if (bd.in_valid && bd.in_ready) begin
        if (in_q[ii].close) in_par = 1'b1;
        exp_err = in_q[ii].trunc;
        ii++;
      end
    end
    check("beats_in", ii, in_q.size());
    check("beats_out", oi, exp_q.size());
    @(negedge clk);
    bd.in_valid  = 1'b0;
    bd.out_ready = 1'b1;
    check("drain_valid", bd.out_valid, 1'b0);
    check("err_tail", bd.err_len, exp_err);
    in_q.delete();
    exp_q.delete();
  endtask

  vec_t tv[10];

  initial begin
    gf_init();
    build_gpoly();
    rst_n = 1'b0;
    bs.in_valid = 1'b0; bs.in_data = '0; bs.in_last = 1'b0; bs.out_ready = 1'b1;
    bd.in_valid = 1'b0; bd.in_data = '0; bd.in_last = 1'b0; bd.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_valid", bs.out_valid, 1'b0);
    check("rst_s_data", bs.out_data, 16'h0);
    check("rst_d_valid", bd.out_valid, 1'b0);
    check("rst_d_data", bd.out_data, 32'h0);
    check("rst_d_last", bd.out_last, 1'b0);
    check("rst_d_err", bd.err_len, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_in_ready", bs.in_ready, 1'b1);
    check("rst_d_in_ready", bd.in_ready, 1'b1);

    tv[0] = '{1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
    tv[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0F36, 1'b0, 1'b0};
    tv[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h7840, 1'b1, 1'b1};
    tv[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tv[4] = '{1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
    tv[5] = '{1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
    tv[6] = '{1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    tv[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    tv[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
    tv[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bs.in_valid = tv[i].v;
      bs.in_data  = tv[i].d;
      bs.in_last  = tv[i].l;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), bs.out_valid, tv[i].ev);
      if (tv[i].ev) begin
        check($sformatf("vec%0d_data", i), bs.out_data, tv[i].ed);
        check($sformatf("vec%0d_last", i), bs.out_last, tv[i].el);
      end
      check($sformatf("vec%0d_in_ready", i), bs.in_ready, tv[i].eir);
    end
    @(negedge clk);
    bs.in_valid = 1'b0;

    // 60 beats without in_last: beat 59 truncates, beat 60 opens a new frame.
    add_frame(60, 1'b0);
    add_frame(1, 1'b1);
    run_stream(100, 100, -1);

    // Five-cycle stall on the second parity beat of a three-beat frame.
    add_frame(3, 1'b1);
    run_stream(100, 100, 4);

    // Random frames with bubbles and backpressure, including a full-length one.
    add_frame(MAXB, 1'b1);
    for (int f = 0; f < 9; f++) add_frame($urandom_range(MAXB, 1), 1'b1);
    run_stream(70, 70, -1);

    // Reset while beat 3 is being offered.
    bd.out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bd.in_valid = 1'b1;
      bd.in_data  = $urandom();
      bd.in_last  = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bd.out_valid, 1'b0);
    check("arst_data", bd.out_data, 32'h0);
    check("arst_last", bd.out_last, 1'b0);
    check("arst_in_ready", bd.in_ready, 1'b1);
    @(negedge clk);
    bd.in_valid = 1'b0;
    rst_n = 1'b1;
    add_frame(1, 1'b1);
    run_stream(100, 100, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
